// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised datapath FIFO.
// Holds the default geometry (10-bit words, 8 entries), the operation
// encoding used by the occupancy update, and the pointer-width-to-depth
// helper used by both the storage array and the control logic.
package fifo_pkg;

    localparam int FIFO_DATA_W = 10;
    localparam int FIFO_ADDR_W = 3;

    // Combined accept pattern for one cycle: {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Number of entries addressed by a pointer of addr_w bits.
    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// fifo_param_if: producer/consumer bus of the datapath FIFO.
// The master modport is the side that pushes and pops (producer and
// consumer stages); the slave modport is the FIFO itself.
interface fifo_param_if import fifo_pkg::*; #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) ();

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [ADDR_W:0]   umbral_bajo;
    logic [ADDR_W:0]   umbral_alto;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en, umbral_bajo, umbral_alto, err_clr,
        input  data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, umbral_bajo, umbral_alto, err_clr,
        output data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage for the datapath FIFO.
// Synchronous write port, asynchronous read port. The read register (if
// any) belongs to the FIFO control so the fall-through option stays local
// to fifo_param. Contents are deliberately not reset.
module fifo_mem import fifo_pkg::*; #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = int'(fifo_depth(ADDR_W));

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store the write word at the edge where the write is accepted.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read before write: on a same-address collision the old word is seen.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO between a producer and a
// consumer stage. Blocked writes (full) and blocked reads (empty) are
// recorded in sticky overflow/underflow flags cleared by err_clr.
// Occupancy is exported and the almost-flags compare live against the
// run-time thresholds umbral_alto / umbral_bajo.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through output
// (data_out shows the head word combinationally, data_valid = !empty).
// Without it, data_out/data_valid are registered with one cycle latency.
module fifo_param import fifo_pkg::*; #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    fifo_param_if.slave  bus
);

    localparam int              DEPTH     = int'(fifo_depth(ADDR_W));
    localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ZERO  = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ovf_set;
    logic              w_udf_set;
    fifo_op_e          w_op;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;
    logic              w_mem_wr;
    logic [DATA_W-1:0] w_rd_data;

    // Accept decisions: a read needs data; a write into a full FIFO only
    // proceeds when a read frees the slot in the same cycle.
    always_comb begin
        w_full    = (r_count == CNT_FULL);
        w_empty   = (r_count == CNT_ZERO);
        w_rd_acc  = bus.rd_en && !w_empty;
        w_wr_acc  = bus.wr_en && (!w_full || w_rd_acc);
        w_ovf_set = bus.wr_en && !w_wr_acc;
        w_udf_set = bus.rd_en && !w_rd_acc;
        w_op      = fifo_op_e'({w_wr_acc, w_rd_acc});
        w_mem_wr  = w_wr_acc && reset;
    end

    // Occupancy update; range 0..DEPTH holds because accepts are gated by full/empty.
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + CNT_ONE;
            OP_RD:   w_count_nxt = r_count - CNT_ONE;
            OP_IDLE: w_count_nxt = r_count;
            OP_RW:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Sticky error flags: a new error in the same cycle wins over err_clr.
    always_comb begin
        if (w_ovf_set) begin
            w_ovf_nxt = 1'b1;
        end else if (bus.err_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_overflow;
        end

        if (w_udf_set) begin
            w_udf_nxt = 1'b1;
        end else if (bus.err_clr) begin
            w_udf_nxt = 1'b0;
        end else begin
            w_udf_nxt = r_underflow;
        end
    end

    // Pointer, occupancy and error state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_count     <= CNT_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_nxt;
            r_underflow <= w_udf_nxt;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Status flags derive from the count register; thresholds are used live.
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= bus.umbral_alto);
    assign bus.almost_empty = (r_count <= bus.umbral_bajo);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en acknowledges and pops it.
    assign bus.data_out   = w_rd_data;
    assign bus.data_valid = !w_empty;
`else
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;

    // Registered read: capture the head word on the popping edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out   <= {DATA_W{1'b0}};
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param (DATA_W=10, ADDR_W=3).
// Stimulus pushes each expected popped word with the cycle it must appear;
// an independent monitor pops and compares whenever the DUT presents data.
module tb_fifo_param;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    exp_t          sb[$];
    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fifo_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    wire mon_take;
`ifdef FIFO_FWFT_EN
    assign mon_take = bus.data_valid && bus.rd_en;
`else
    assign mon_take = bus.data_valid;
`endif

    // Monitor: every presented word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_take === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: data_valid with data_out=%0h, expected no word", bus.data_out);
            end else begin
                e = sb.pop_front();
                chk("rd_data", 32'(bus.data_out), 32'(e.data));
                chk("rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic check_status(input bit after_reset);
        int n;
        n = m_q.size();
        chk("count", 32'(bus.count), 32'(n));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= int'(bus.umbral_alto)));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= int'(bus.umbral_bajo)));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
        if (after_reset) begin
            chk("valid_after_reset", 32'(bus.data_valid), 32'd0);
        end
    endtask

    // One clock cycle: drive, update the reference queue, then check status.
    task automatic step(input logic rst_n, input logic wr, input logic [DW-1:0] d,
                        input logic rd, input logic clr);
        bit   racc;
        bit   wacc;
        exp_t e;
        reset       = rst_n;
        bus.wr_en   = wr;
        bus.data_in = d;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            racc = rd && (m_q.size() != 0);
            wacc = wr && ((m_q.size() != DEPTH) || racc);
            if (racc) begin
                e.data = m_q.pop_front();
`ifdef FIFO_FWFT_EN
                e.due  = cyc;
`else
                e.due  = cyc + 1;
`endif
                sb.push_back(e);
            end
            if (wacc) m_q.push_back(d);
            if (wr && !wacc) m_ovf = 1'b1;
            else if (clr)    m_ovf = 1'b0;
            if (rd && !racc) m_udf = 1'b1;
            else if (clr)    m_udf = 1'b0;
        end
        @(posedge clk);
        #1;
        check_status(!rst_n);
    endtask

    initial begin
        reset           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.err_clr     = 1'b0;
        bus.data_in     = 10'h000;
        bus.umbral_alto = 4'd0;
        bus.umbral_bajo = 4'd2;
        @(posedge clk);
        #1;

        // Reset state; almost_full follows umbral_alto == 0.
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);

        // Fill 0x001..0x008: almost_full at 6, full at 8.
        bus.umbral_alto = 4'd6;
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 10'(i), 1'b0, 1'b0);

        // Write into full: rejected, overflow set; then err_clr.
        step(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'h000, 1'b0, 1'b1);

        // Drain: 0x001..0x008 in order, 0x3FF never appears.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h000, 1'b1, 1'b0);

        // Read on empty, then read+write on empty (write kept, read rejected).
        step(1'b1, 1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'h0AA, 1'b1, 1'b0);
        // Read+write at count 1 returns the old head 0x0AA.
        step(1'b1, 1'b1, 10'h0BB, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'h000, 1'b0, 1'b1);

        // Refill to full, then 20 cycles of read+write across the pointer wrap.
        for (int i = 0; i < 7; i++)  step(1'b1, 1'b1, 10'(12'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 10'(12'h200 + i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 10'h000, 1'b1, 1'b0);

        // Underflow, 5 writes, then reset mid-operation clears everything.
        bus.umbral_bajo = 4'd0;
        step(1'b1, 1'b0, 10'h000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 10'(12'h300 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);

`ifdef FIFO_FWFT_EN
        // Fall-through: word visible the cycle after its write, no rd_en needed.
        step(1'b1, 1'b1, 10'h155, 1'b0, 1'b0);
        chk("fwft_data", 32'(bus.data_out), 32'h155);
        chk("fwft_valid", 32'(bus.data_valid), 32'd1);
        step(1'b1, 1'b0, 10'h000, 1'b1, 1'b0);
        chk("fwft_empty_after_pop", 32'(bus.empty), 32'd1);
`endif

        step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
